// File: rtl/mt9v034_sync_pkg.sv
// Shared definitions for the MT9V034 embedded-sync decoder.
//   sync_state_t : per-lane framing state (vertical blank, horizontal blank, active line)
//   sync_code_t  : code word recognised on the incoming word (NONE when no sync pattern)
//   word_tag_t   : attributes attached to every word as it enters a lane's delay line
//   code_*()     : sync code values for a given channel word width
package mt9v034_sync_pkg;

  typedef enum logic [1:0] {
    ST_VBLANK = 2'd0,
    ST_HBLANK = 2'd1,
    ST_ACTIVE = 2'd2
  } sync_state_t;

  typedef enum logic [2:0] {
    CODE_NONE = 3'd0,
    CODE_FS   = 3'd1,
    CODE_FE   = 3'd2,
    CODE_LS   = 3'd3,
    CODE_LE   = 3'd4
  } sync_code_t;

  typedef struct packed {
    logic kill;    // word belongs to a sync sequence and must be blanked
    logic active;  // word entered while the lane was inside an active line
    logic lv;      // line valid
    logic fv;      // frame valid
  } word_tag_t;

  localparam int PIX_CNT_W  = 12;
  localparam int LINE_CNT_W = 11;

  // The two preamble words (ONES, ZERO) that precede LE are counted as
  // active when they enter, before the LE word reveals them as sync.
  localparam int PREAMBLE_LEN = 2;

  function automatic logic [15:0] code_ones(input int width);
    return 16'((32'd1 << width) - 32'd1);
  endfunction

  function automatic logic [15:0] code_fe(input int width);
    return code_ones(width) - 16'd1;
  endfunction

  function automatic logic [15:0] code_ls(input int width);
    return (width > 0) ? 16'd1 : 16'd0;
  endfunction

  function automatic logic [15:0] code_le(input int width);
    return (width > 0) ? 16'd0 : 16'd0;
  endfunction

  function automatic word_tag_t mark_kill(input word_tag_t t, input logic k);
    word_tag_t r;
    r      = t;
    r.kill = t.kill | k;
    return r;
  endfunction

endpackage

// File: rtl/mt9v034_sync_channel.sv
// One lane of the embedded-sync decoder.
//   pxclk, reset      : clock, synchronous active-high reset
//   push              : a new word is present on word_in
//   word_in           : deserialised channel word
//   err_clear         : clears the sticky error flags
//   out_data/active/lv/fv : registered word leaving the 3-deep delay line
//   code, code_det    : code decoded on the incoming word (for the lockstep check)
//   frame_done        : legal FE seen (only when COUNT_FRAMES is set)
//   sync_error        : sticky, illegal sync sequence
//   size_error        : sticky, pixel or line count mismatch
module mt9v034_sync_channel
  import mt9v034_sync_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int VIDEO_BIT_WIDTH = 8,
  parameter int FRAME_WIDTH     = 752,
  parameter int FRAME_HEIGHT    = 480,
  parameter bit COUNT_FRAMES    = 1'b0
) (
  input  logic                       pxclk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [INPUT_BIT_WIDTH-1:0] word_in,
  input  logic                       err_clear,
  output logic [VIDEO_BIT_WIDTH-1:0] out_data,
  output logic                       out_active,
  output logic                       out_lv,
  output logic                       out_fv,
  output sync_code_t                 code,
  output logic                       code_det,
  output logic                       frame_done,
  output logic                       sync_error,
  output logic                       size_error
);

  localparam int IBW = INPUT_BIT_WIDTH;
  localparam int VBW = VIDEO_BIT_WIDTH;

  localparam logic [IBW-1:0] W_ONES = IBW'(code_ones(IBW));
  localparam logic [IBW-1:0] W_ZERO = '0;
  localparam logic [IBW-1:0] W_FS   = W_ONES;
  localparam logic [IBW-1:0] W_FE   = IBW'(code_fe(IBW));
  localparam logic [IBW-1:0] W_LS   = IBW'(code_ls(IBW));
  localparam logic [IBW-1:0] W_LE   = IBW'(code_le(IBW));

  localparam logic [PIX_CNT_W-1:0]  PIX_AT_LE  = PIX_CNT_W'(FRAME_WIDTH + PREAMBLE_LEN);
  localparam logic [LINE_CNT_W-1:0] LINE_AT_FE = LINE_CNT_W'(FRAME_HEIGHT);

  sync_state_t state, state_nx;

  // dly_*[0] is the newest word, dly_*[2] the oldest.
  logic [IBW-1:0] dly_data [3];
  word_tag_t      dly_tag  [3];
  word_tag_t      in_tag;

  logic [PIX_CNT_W-1:0]  pix_cnt;
  logic [LINE_CNT_W-1:0] line_cnt;

  logic sync_err_set, size_err_set, fe_ok;
  logic pix_clr, line_clr, line_inc;

  // Sync detection looks at the two buffered words plus the incoming one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    code = CODE_NONE;
    if (dly_data[1] == W_ONES && dly_data[0] == W_ZERO) begin
      if      (word_in == W_FS) code = CODE_FS;
      else if (word_in == W_FE) code = CODE_FE;
      else if (word_in == W_LS) code = CODE_LS;
      else if (word_in == W_LE) code = CODE_LE;
    end
  end

  assign code_det = push && (code != CODE_NONE);

  assign in_tag = '{kill:   code_det,
                    active: (state == ST_ACTIVE) && !code_det,
                    lv:     (state == ST_ACTIVE),
                    fv:     (state != ST_VBLANK)};

  // Next-state: a code always moves the lane to the code's target state;
  // arriving from the wrong state flags a sync error (resync).
  always_comb begin
    state_nx     = state;
    sync_err_set = 1'b0;
    size_err_set = 1'b0;
    fe_ok        = 1'b0;
    pix_clr      = 1'b0;
    line_clr     = 1'b0;
    line_inc     = 1'b0;
    if (code_det) begin
      case (code)
        CODE_FS: begin
          state_nx = ST_HBLANK;
          line_clr = 1'b1;
          if (state != ST_VBLANK) sync_err_set = 1'b1;
        end
        CODE_LS: begin
          state_nx = ST_ACTIVE;
          pix_clr  = 1'b1;
          if (state != ST_HBLANK) sync_err_set = 1'b1;
        end
        CODE_LE: begin
          state_nx = ST_HBLANK;
          if (state != ST_ACTIVE) begin
            sync_err_set = 1'b1;
          end else begin
            line_inc = 1'b1;
            if (pix_cnt != PIX_AT_LE) size_err_set = 1'b1;
          end
        end
        CODE_FE: begin
          state_nx = ST_VBLANK;
          if (state != ST_HBLANK) begin
            sync_err_set = 1'b1;
          end else begin
            fe_ok = 1'b1;
            if (line_cnt != LINE_AT_FE) size_err_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign frame_done = COUNT_FRAMES && fe_ok;

  always_ff @(posedge pxclk) begin
    if (reset) state <= ST_VBLANK;
    else       state <= state_nx;
  end

  always_ff @(posedge pxclk) begin
    if (reset) begin
      // NOTE: the delay line is reset as well, so a mid-frame reset cannot leak stale words to the output.
      for (int i = 0; i < 3; i++) begin
        dly_data[i] <= '0;
        dly_tag[i]  <= '0;
      end
      out_data   <= '0;
      out_active <= 1'b0;
      out_lv     <= 1'b0;
      out_fv     <= 1'b0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      sync_error <= 1'b0;
      size_error <= 1'b0;
    end else begin
      if (push) begin
        // NOTE: non-blocking assignments let the whole shift happen from the pre-edge values.
        dly_data[0] <= word_in;
        dly_data[1] <= dly_data[0];
        dly_data[2] <= dly_data[1];
        dly_tag[0]  <= in_tag;
        dly_tag[1]  <= mark_kill(dly_tag[0], code_det);
        dly_tag[2]  <= mark_kill(dly_tag[1], code_det);

        out_data   <= dly_tag[2].kill ? '0 : dly_data[2][IBW-1 -: VBW];
        out_active <= dly_tag[2].active & ~dly_tag[2].kill;
        out_lv     <= dly_tag[2].lv;
        out_fv     <= dly_tag[2].fv;

        if (pix_clr)
          pix_cnt <= '0;
        else if (state == ST_ACTIVE && !code_det && pix_cnt != '1)
          pix_cnt <= pix_cnt + 1'b1;

        if (line_clr)
          line_cnt <= '0;
        else if (line_inc && line_cnt != '1)
          line_cnt <= line_cnt + 1'b1;
      end
      // A new error in the same cycle as err_clear keeps the flag set.
      sync_error <= (sync_error & ~err_clear) | sync_err_set;
      size_error <= (size_error & ~err_clear) | size_err_set;
    end
  end

endmodule

// File: rtl/mt9v034_multi_sync_decoder.sv
// N-channel embedded-sync decoder for MT9V034 LVDS streams.
//   pxclk, reset       : pixel clock, synchronous active-high reset
//   rx_data_valid      : payload qualifier, common to all channels
//   rx_data_payload    : channel c at [c*INPUT_BIT_WIDTH +: INPUT_BIT_WIDTH]
//   err_clear          : clears all sticky error flags
//   pixel_data_valid   : output word strobe
//   vid_data           : channel c at [c*VIDEO_BIT_WIDTH +: VIDEO_BIT_WIDTH]
//   vid_active_video, vid_hblank, vid_vblank : per-channel video timing
//   frame_count        : completed frames on channel 0
//   sync_error, size_error : per-channel sticky flags
//   skew_error         : sticky, channels decoded different codes on the same word
module mt9v034_multi_sync_decoder
  import mt9v034_sync_pkg::*;
#(
  parameter int NUM_CHANNELS    = 2,
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int VIDEO_BIT_WIDTH = 8,
  parameter int FRAME_WIDTH     = 752,
  parameter int FRAME_HEIGHT    = 480
) (
  input  logic                                    pxclk,
  input  logic                                    reset,
  input  logic                                    rx_data_valid,
  input  logic [NUM_CHANNELS*INPUT_BIT_WIDTH-1:0] rx_data_payload,
  input  logic                                    err_clear,
  output logic                                    pixel_data_valid,
  output logic [NUM_CHANNELS*VIDEO_BIT_WIDTH-1:0] vid_data,
  output logic [NUM_CHANNELS-1:0]                 vid_active_video,
  output logic [NUM_CHANNELS-1:0]                 vid_hblank,
  output logic [NUM_CHANNELS-1:0]                 vid_vblank,
  output logic [15:0]                             frame_count,
  output logic [NUM_CHANNELS-1:0]                 sync_error,
  output logic [NUM_CHANNELS-1:0]                 size_error,
  output logic                                    skew_error
);

  localparam int IBW = INPUT_BIT_WIDTH;
  localparam int VBW = VIDEO_BIT_WIDTH;

  logic [NUM_CHANNELS-1:0] ch_det, ch_done, ch_lv, ch_fv;
  sync_code_t              ch_code [NUM_CHANNELS];
  logic                    skew_mismatch, skew_hit;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
    // Only lane 0 reports frame completion, so ORing the strobes below
    // yields channel 0's FE.
    mt9v034_sync_channel #(
      .INPUT_BIT_WIDTH (IBW),
      .VIDEO_BIT_WIDTH (VBW),
      .FRAME_WIDTH     (FRAME_WIDTH),
      .FRAME_HEIGHT    (FRAME_HEIGHT),
      .COUNT_FRAMES    (c == 0)
    ) u_lane (
      .pxclk      (pxclk),
      .reset      (reset),
      .push       (rx_data_valid),
      .word_in    (rx_data_payload[c*IBW +: IBW]),
      .err_clear  (err_clear),
      .out_data   (vid_data[c*VBW +: VBW]),
      .out_active (vid_active_video[c]),
      .out_lv     (ch_lv[c]),
      .out_fv     (ch_fv[c]),
      .code       (ch_code[c]),
      .code_det   (ch_det[c]),
      .frame_done (ch_done[c]),
      .sync_error (sync_error[c]),
      .size_error (size_error[c])
    );
  end

  assign vid_hblank = ~ch_lv;
  assign vid_vblank = ~ch_fv;

  // On a word where any lane sees a code, every lane must see that same code
  // (a lane with no code reports CODE_NONE and therefore mismatches).
  always_comb begin
    skew_mismatch = 1'b0;
    for (int c = 1; c < NUM_CHANNELS; c++) begin
      if (ch_code[c] != ch_code[0]) skew_mismatch = 1'b1;
    end
  end

  assign skew_hit = (|ch_det) && skew_mismatch;

  always_ff @(posedge pxclk) begin
    if (reset) begin
      pixel_data_valid <= 1'b0;
      frame_count      <= '0;
      skew_error       <= 1'b0;
    end else begin
      pixel_data_valid <= rx_data_valid;
      if (|ch_done) frame_count <= frame_count + 16'd1;
      skew_error <= (skew_error & ~err_clear) | skew_hit;
    end
  end

endmodule

// File: tb/tb_mt9v034_multi_sync_decoder.sv
// Directed bench for the 2-lane decoder with a 4x2 frame geometry.
module tb_mt9v034_multi_sync_decoder;

  logic        pxclk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_data_valid = 1'b0;
  logic [15:0] rx_data_payload = '0;
  logic        err_clear = 1'b0;
  logic        pixel_data_valid;
  logic [15:0] vid_data;
  logic [1:0]  vid_active_video, vid_hblank, vid_vblank;
  logic [15:0] frame_count;
  logic [1:0]  sync_error, size_error;
  logic        skew_error;

  mt9v034_multi_sync_decoder #(
    .NUM_CHANNELS    (2),
    .INPUT_BIT_WIDTH (8),
    .VIDEO_BIT_WIDTH (8),
    .FRAME_WIDTH     (4),
    .FRAME_HEIGHT    (2)
  ) u_dut (
    .pxclk            (pxclk),
    .reset            (reset),
    .rx_data_valid    (rx_data_valid),
    .rx_data_payload  (rx_data_payload),
    .err_clear        (err_clear),
    .pixel_data_valid (pixel_data_valid),
    .vid_data         (vid_data),
    .vid_active_video (vid_active_video),
    .vid_hblank       (vid_hblank),
    .vid_vblank       (vid_vblank),
    .frame_count      (frame_count),
    .sync_error       (sync_error),
    .size_error       (size_error),
    .skew_error       (skew_error)
  );

  always #5 pxclk = ~pxclk;

  // One record per input word: the word on each lane and how that word must
  // look when it leaves the delay line (k: blanked sync word, a: active,
  // lv/fv: line/frame valid at the time it entered).
  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    logic       k;
    logic       a;
    logic       lv;
    logic       fv;
  } vec_t;

  vec_t tbl [$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_act;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] w, input logic [3:0] kalf);
    vec_t v;
    v.w0 = w; v.w1 = w;
    v.k = kalf[3]; v.a = kalf[2]; v.lv = kalf[1]; v.fv = kalf[0];
    tbl.push_back(v);
  endtask

  // Legal 4x2 frame; line 1 carries pixel values that look like preamble words.
  task automatic build_frame();
    tbl.delete();
    add(8'h10, 4'b0000);
    add(8'hFF, 4'b1000); add(8'h00, 4'b1000); add(8'hFF, 4'b1000);   // FS
    add(8'h10, 4'b0001);
    add(8'hFF, 4'b1001); add(8'h00, 4'b1001); add(8'h01, 4'b1001);   // LS
    add(8'hFF, 4'b0111); add(8'h00, 4'b0111); add(8'h55, 4'b0111); add(8'hAA, 4'b0111);
    add(8'hFF, 4'b1011); add(8'h00, 4'b1011); add(8'h00, 4'b1011);   // LE
    add(8'h10, 4'b0001);
    add(8'hFF, 4'b1001); add(8'h00, 4'b1001); add(8'h01, 4'b1001);   // LS
    add(8'h11, 4'b0111); add(8'h22, 4'b0111); add(8'h33, 4'b0111); add(8'h44, 4'b0111);
    add(8'hFF, 4'b1011); add(8'h00, 4'b1011); add(8'h00, 4'b1011);   // LE
    add(8'h10, 4'b0001);
    add(8'hFF, 4'b1001); add(8'h00, 4'b1001); add(8'hFE, 4'b1001);   // FE
    add(8'h10, 4'b0000); add(8'h10, 4'b0000); add(8'h10, 4'b0000); add(8'h10, 4'b0000);
  endtask

  task automatic push2(input logic [7:0] a, input logic [7:0] b, input logic clr);
    rx_data_valid   = 1'b1;
    rx_data_payload = {b, a};
    err_clear       = clr;
    @(posedge pxclk); #1;
    rx_data_valid = 1'b0;
    err_clear     = 1'b0;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    rx_data_valid = 1'b0;
    @(posedge pxclk); #1;
    reset = 1'b0;
  endtask

  // Plays tbl; after each push the output must be the word pushed three
  // words earlier (pre_w with a blank tag while the line is still filling).
  task automatic run(input bit gaps, input bit lockstep, input logic [7:0] pre_w, output int acts);
    vec_t       e;
    logic [7:0] ew0, ew1;
    acts = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i >= 3) begin
        e = tbl[i-3];
      end else begin
        e.w0 = pre_w; e.w1 = pre_w; e.k = 1'b0; e.a = 1'b0; e.lv = 1'b0; e.fv = 1'b0;
      end
      push2(tbl[i].w0, tbl[i].w1, 1'b0);
      ew0 = e.k ? 8'h00 : e.w0;
      ew1 = e.k ? 8'h00 : e.w1;
      check($sformatf("vec%0d ch0 {pdv,data,act,hb,vb}", i),
            {pixel_data_valid, vid_data[7:0], vid_active_video[0], vid_hblank[0], vid_vblank[0]},
            {1'b1, ew0, e.a, ~e.lv, ~e.fv});
      if (lockstep)
        check($sformatf("vec%0d ch1 {data,act,hb,vb}", i),
              {vid_data[15:8], vid_active_video[1], vid_hblank[1], vid_vblank[1]},
              {ew1, e.a, ~e.lv, ~e.fv});
      if (vid_active_video[0]) acts++;
      if (gaps) begin
        @(posedge pxclk); #1;
        check($sformatf("gap%0d pdv", i), pixel_data_valid, 1'b0);
      end
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    check("reset pdv", pixel_data_valid, 1'b0);
    check("reset vid_data", vid_data, 16'h0000);
    check("reset active", vid_active_video, 2'b00);
    check("reset hblank", vid_hblank, 2'b11);
    check("reset vblank", vid_vblank, 2'b11);
    check("reset frame_count", frame_count, 16'd0);
    check("reset errors", {sync_error, size_error, skew_error}, 5'b0);

    // Legal frame, back-to-back words
    build_frame();
    run(1'b0, 1'b1, 8'h00, n_act);
    check("frame active words", n_act, 8);
    check("frame frame_count", frame_count, 16'd1);
    check("frame errors", {sync_error, size_error, skew_error}, 5'b0);

    // Same frame with a gap after every word
    do_reset();
    run(1'b1, 1'b1, 8'h00, n_act);
    check("gapped active words", n_act, 8);
    check("gapped frame_count", frame_count, 16'd1);
    check("gapped errors", {sync_error, size_error, skew_error}, 5'b0);

    // Lane 1 LS one word behind lane 0
    do_reset();
    push2(8'h10, 8'h10, 1'b0);
    push2(8'hFF, 8'hFF, 1'b0); push2(8'h00, 8'h00, 1'b0); push2(8'hFF, 8'hFF, 1'b0);
    check("skew after common FS", skew_error, 1'b0);
    push2(8'hFF, 8'h10, 1'b0); push2(8'h00, 8'hFF, 1'b0);
    push2(8'h01, 8'h00, 1'b0);
    check("skew lane0 LS alone", skew_error, 1'b1);
    err_clear = 1'b1;
    @(posedge pxclk); #1;
    err_clear = 1'b0;
    check("skew cleared", skew_error, 1'b0);
    push2(8'h55, 8'h01, 1'b0);
    check("skew lane1 LS alone", skew_error, 1'b1);
    check("skew no sync error", sync_error, 2'b00);

    // Short first line, then good line, then a good frame: flag stays set
    do_reset();
    push2(8'h10, 8'h10, 1'b0);
    push2(8'hFF, 8'hFF, 1'b0); push2(8'h00, 8'h00, 1'b0); push2(8'hFF, 8'hFF, 1'b0);
    push2(8'h10, 8'h10, 1'b0);
    push2(8'hFF, 8'hFF, 1'b0); push2(8'h00, 8'h00, 1'b0); push2(8'h01, 8'h01, 1'b0);
    push2(8'h11, 8'h11, 1'b0); push2(8'h22, 8'h22, 1'b0); push2(8'h33, 8'h33, 1'b0);
    push2(8'hFF, 8'hFF, 1'b0); push2(8'h00, 8'h00, 1'b0);
    check("size before LE", size_error, 2'b00);
    push2(8'h00, 8'h00, 1'b0);
    check("size at short LE", size_error, 2'b11);
    push2(8'h10, 8'h10, 1'b0);
    push2(8'hFF, 8'hFF, 1'b0); push2(8'h00, 8'h00, 1'b0); push2(8'h01, 8'h01, 1'b0);
    push2(8'h11, 8'h11, 1'b0); push2(8'h22, 8'h22, 1'b0); push2(8'h33, 8'h33, 1'b0);
    push2(8'h44, 8'h44, 1'b0);
    push2(8'hFF, 8'hFF, 1'b0); push2(8'h00, 8'h00, 1'b0); push2(8'h00, 8'h00, 1'b0);
    push2(8'h10, 8'h10, 1'b0);
    push2(8'hFF, 8'hFF, 1'b0); push2(8'h00, 8'h00, 1'b0); push2(8'hFE, 8'hFE, 1'b0);
    for (int i = 0; i < 4; i++) push2(8'h10, 8'h10, 1'b0);
    check("size short-frame count", frame_count, 16'd1);
    run(1'b0, 1'b1, 8'h10, n_act);
    check("size sticky", size_error, 2'b11);
    check("size good-frame count", frame_count, 16'd2);
    check("size no sync error", sync_error, 2'b00);
    err_clear = 1'b1;
    @(posedge pxclk); #1;
    err_clear = 1'b0;
    check("size cleared", size_error, 2'b00);

    // LE in HBLANK, error-wins-over-clear, then a normal LS
    do_reset();
    push2(8'h10, 8'h10, 1'b0);
    push2(8'hFF, 8'hFF, 1'b0); push2(8'h00, 8'h00, 1'b0); push2(8'hFF, 8'hFF, 1'b0);
    push2(8'h10, 8'h10, 1'b0);
    push2(8'hFF, 8'hFF, 1'b0); push2(8'h00, 8'h00, 1'b0); push2(8'h00, 8'h00, 1'b0);
    check("sync LE in HBLANK", sync_error, 2'b11);
    push2(8'hFF, 8'hFF, 1'b0); push2(8'h00, 8'h00, 1'b0); push2(8'h00, 8'h00, 1'b1);
    check("sync error wins over clear", sync_error, 2'b11);
    err_clear = 1'b1;
    @(posedge pxclk); #1;
    err_clear = 1'b0;
    check("sync cleared", sync_error, 2'b00);
    push2(8'h10, 8'h10, 1'b0);
    push2(8'hFF, 8'hFF, 1'b0); push2(8'h00, 8'h00, 1'b0); push2(8'h01, 8'h01, 1'b0);
    push2(8'h5A, 8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) push2(8'h10, 8'h10, 1'b0);
    check("resync pixel active", vid_active_video, 2'b11);
    check("resync pixel data", vid_data, 16'h5A5A);
    check("resync no new sync error", sync_error, 2'b00);

    // Reset in the middle of a line
    do_reset();
    build_frame();
    run(1'b0, 1'b1, 8'h00, n_act);
    push2(8'h10, 8'h10, 1'b0);
    push2(8'hFF, 8'hFF, 1'b0); push2(8'h00, 8'h00, 1'b0); push2(8'h01, 8'h01, 1'b0);
    push2(8'h11, 8'h11, 1'b0); push2(8'h22, 8'h22, 1'b0);
    do_reset();
    check("midreset vblank", vid_vblank, 2'b11);
    check("midreset hblank", vid_hblank, 2'b11);
    check("midreset active", vid_active_video, 2'b00);
    check("midreset frame_count", frame_count, 16'd0);
    for (int i = 0; i < 6; i++) begin
      push2(8'h55 + 8'(i), 8'h55 + 8'(i), 1'b0);
      check($sformatf("post-reset word%0d active", i), vid_active_video, 2'b00);
    end
    check("post-reset sync error", sync_error, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
